// File: rtl/apb_csr_bank_pkg.sv
// Shared types and helpers for the APB CSR bank.
// Holds the transfer FSM states and the per-bit merge rule.
package apb_csr_bank_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_e;

   localparam int WOFF_W = 2;
   localparam int STRB_W = 4;

   // RW takes write data, W1C clears on 1 unless set
   // this cycle, RO follows the hardware load strobe.
   function automatic logic [31:0] csr_merge(
      input logic [31:0] cur,
      input logic [31:0] wdata,
      input logic [31:0] wen,
      input logic [31:0] rw,
      input logic [31:0] w1c,
      input logic        hw_ld,
      input logic [31:0] hw_d,
      input logic [31:0] set
   );
      logic [31:0] ro;
      logic [31:0] n;
      ro = ~(rw | w1c);
      n  = cur;
      n  = (n & ~(wen & rw)) | (wdata & wen & rw);
      n  = n & ~(wen & w1c & wdata);
      n  = n | (set & w1c);
      if (hw_ld) begin
         n = (n & ~ro) | (hw_d & ro);
      end
      return n;
   endfunction

endpackage

// File: rtl/apb_csr_bank_ctrl.sv
// APB transfer FSM, wait counter, decode and error flags.
// APB_CSR_BANK_SEC_EN enables secure-register checks.
module apb_csr_bank_ctrl
   import apb_csr_bank_pkg::*;
#(
   parameter int                NUM_REGS    = 4,
   parameter int                ADDR_WIDTH  = 16,
   parameter int                WAIT_STATES = 0,
   parameter bit                WPROT_ERR   = 1'b1,
   parameter logic [NUM_REGS-1:0] SEC_MASK  = '0,
   parameter int                IDX_W       = $clog2(NUM_REGS)
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [2:0]            pprot,
   input  logic                  write_protect_en,
   output logic                  pready,
   output logic                  pslverr,
   output logic                  rd_ok,
   output logic                  wr_commit,
   output logic [IDX_W-1:0]      idx
);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        pready_q, pready_d;
   logic        in_range;
   logic        sec_err;
   logic        dec_err;
   logic        complete;
   logic [ADDR_WIDTH-WOFF_W-1:0] word;

   assign word     = paddr[ADDR_WIDTH-1:WOFF_W];
   assign idx      = word[IDX_W-1:0];
   assign in_range = 32'(word) < NUM_REGS;

`ifdef APB_CSR_BANK_SEC_EN
   logic unused_prot;
   assign unused_prot = pprot[0] ^ pprot[2];
   assign sec_err     = pprot[1] & SEC_MASK[idx];
`else
   logic unused_sec;
   assign unused_sec = ^{pprot, SEC_MASK};
   assign sec_err    = 1'b0;
`endif

   assign dec_err   = (paddr[1:0] != 2'b00) | ~in_range | sec_err;
   assign complete  = pready_q & psel & penable;
   assign pready    = pready_q;
   assign pslverr   = pready_q &
                      (dec_err | (pwrite & write_protect_en & WPROT_ERR));
   assign rd_ok     = pready_q & ~dec_err;
   assign wr_commit = complete & pwrite & ~dec_err & ~write_protect_en;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               if (WAIT_STATES == 0) begin
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 3'(WAIT_STATES);
               end
            end
         end
         WAIT: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q == 3'd1) begin
               state_d = DONE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         DONE: begin
            if (!psel || penable) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      pready_d = (state_d == DONE);
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         pready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pready_q <= pready_d;
      end
   end

endmodule

// File: rtl/apb_csr_bank.sv
// Parametrised APB CSR bank with RW/W1C/RO bits and level irq.
// Define APB_CSR_BANK_SEC_EN to enforce SEC_MASK on pprot[1].
module apb_csr_bank
   import apb_csr_bank_pkg::*;
#(
   parameter int NUM_REGS     = 4,
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int WAIT_STATES  = 0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RW_MASK   = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] W1C_MASK  = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0,
   parameter logic [NUM_REGS-1:0]            SEC_MASK  = '0,
   parameter bit WPROT_ERR    = 1'b1,
   parameter int IRQ_STAT_IDX = 0,
   parameter int IRQ_EN_IDX   = 1
) (
   input  logic                           pclk,
   input  logic                           preset_n,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   input  logic [2:0]                     pprot,
   output logic                           pready,
   output logic                           pslverr,
   output logic [DATA_WIDTH-1:0]          prdata,
   input  logic                           write_protect_en,
   input  logic [NUM_REGS-1:0]            hw_we,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse,
   output logic                           irq
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int DW    = DATA_WIDTH;

   logic [DW-1:0]       regs_q [NUM_REGS];
   logic [DW-1:0]       regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
   logic                irq_q, irq_d;
   logic [DW-1:0]       bit_en;
   logic                rd_ok;
   logic                wr_commit;
   logic [IDX_W-1:0]    idx;

   apb_csr_bank_ctrl #(
      .NUM_REGS    (NUM_REGS),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WAIT_STATES (WAIT_STATES),
      .WPROT_ERR   (WPROT_ERR),
      .SEC_MASK    (SEC_MASK),
      .IDX_W       (IDX_W)
   ) u_ctrl (
      .pclk             (pclk),
      .preset_n         (preset_n),
      .psel             (psel),
      .penable          (penable),
      .pwrite           (pwrite),
      .paddr            (paddr),
      .pprot            (pprot),
      .write_protect_en (write_protect_en),
      .pready           (pready),
      .pslverr          (pslverr),
      .rd_ok            (rd_ok),
      .wr_commit        (wr_commit),
      .idx              (idx)
   );

   always_comb begin
      bit_en = '0;
      for (int b = 0; b < STRB_W; b++) begin
         bit_en[b*8 +: 8] = {8{pstrb[b]}};
      end
   end

   always_comb begin
      wr_pulse_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_pulse_d[i] = wr_commit && (idx == IDX_W'(i));
         regs_d[i] = csr_merge(regs_q[i], pwdata,
                               bit_en & {DW{wr_pulse_d[i]}},
                               RW_MASK[i*DW +: DW],
                               W1C_MASK[i*DW +: DW],
                               hw_we[i],
                               hw_wdata[i*DW +: DW],
                               hw_set[i*DW +: DW]);
      end
      irq_d = |(regs_q[IRQ_STAT_IDX] & regs_q[IRQ_EN_IDX]);
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL[i*DW +: DW];
         end
         wr_pulse_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wr_pulse_q <= wr_pulse_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_q[i*DW +: DW] = regs_q[i];
      end
   end

   assign prdata       = rd_ok ? regs_q[idx] : '0;
   assign reg_wr_pulse = wr_pulse_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_apb_csr_bank.sv
// Directed bench for apb_csr_bank: 4 regs, 2 wait states.
// reg0 W1C status, reg1 RW enable, reg2 half RW, reg3 RO.
module tb_apb_csr_bank;

   localparam logic [127:0] RSTV =
      {32'hDEADBEEF, 32'h5A000000, 32'h0, 32'h12000000};
   localparam logic [127:0] RWM =
      {32'h0, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0};
   localparam logic [127:0] W1CM = {96'h0, 32'h000000FF};

   logic         pclk = 1'b0;
   logic         preset_n = 1'b0;
   logic         psel = 1'b0;
   logic         penable = 1'b0;
   logic         pwrite = 1'b0;
   logic [15:0]  paddr = '0;
   logic [31:0]  pwdata = '0;
   logic [3:0]   pstrb = '0;
   logic [2:0]   pprot = '0;
   logic         pready;
   logic         pslverr;
   logic [31:0]  prdata;
   logic         write_protect_en = 1'b0;
   logic [3:0]   hw_we = '0;
   logic [127:0] hw_wdata = '0;
   logic [127:0] hw_set = '0;
   logic [127:0] reg_q;
   logic [3:0]   reg_wr_pulse;
   logic         irq;

   int          checks = 0;
   int          passed = 0;
   logic [31:0] rd;
   logic        er;
   int          lat;
   logic [31:0] e [4];

   apb_csr_bank #(
      .NUM_REGS    (4),
      .ADDR_WIDTH  (16),
      .DATA_WIDTH  (32),
      .WAIT_STATES (2),
      .RW_MASK     (RWM),
      .W1C_MASK    (W1CM),
      .RESET_VAL   (RSTV),
      .SEC_MASK    (4'b0010),
      .WPROT_ERR   (1'b1),
      .IRQ_STAT_IDX(0),
      .IRQ_EN_IDX  (1)
   ) dut (
      .pclk             (pclk),
      .preset_n         (preset_n),
      .psel             (psel),
      .penable          (penable),
      .pwrite           (pwrite),
      .paddr            (paddr),
      .pwdata           (pwdata),
      .pstrb            (pstrb),
      .pprot            (pprot),
      .pready           (pready),
      .pslverr          (pslverr),
      .prdata           (prdata),
      .write_protect_en (write_protect_en),
      .hw_we            (hw_we),
      .hw_wdata         (hw_wdata),
      .hw_set           (hw_set),
      .reg_q            (reg_q),
      .reg_wr_pulse     (reg_wr_pulse),
      .irq              (irq)
   );

   always #5 pclk = ~pclk;

   // Starts just after a rising edge; returns just after completion.
   task apb(input logic [15:0] a, input logic [31:0] wd,
            input logic [3:0] st, input logic wr,
            input logic [2:0] pr);
      paddr = a; pwdata = wd; pstrb = st; pwrite = wr; pprot = pr;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      lat = 1;
      while (!pready && lat < 20) begin
         @(posedge pclk); #1;
         lat++;
      end
      checks++;
      if (!pready) $display("FAIL apb_timeout addr=%h", a);
      else passed++;
      rd = prdata;
      er = pslverr;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pprot = 3'b000;
   endtask

   task test_reset();
      e[0] = 32'h12000000; e[1] = 32'h0;
      e[2] = 32'h5A000000; e[3] = 32'hDEADBEEF;
      repeat (2) @(posedge pclk);
      #1;
      checks++;
      if ({pready, pslverr, irq, reg_wr_pulse} !== 7'd0)
         $display("FAIL rst_flags got=%b exp=0",
                  {pready, pslverr, irq, reg_wr_pulse});
      else passed++;
      checks++;
      if (prdata !== 32'h0) $display("FAIL rst_prdata got=%h exp=0", prdata);
      else passed++;
      checks++;
      if (reg_q !== RSTV) $display("FAIL rst_regq got=%h exp=%h", reg_q, RSTV);
      else passed++;
      preset_n = 1'b1;
      @(posedge pclk); #1;
      for (int i = 0; i < 4; i++) begin
         apb(16'(i * 4), 32'h0, 4'h0, 1'b0, 3'b000);
         checks++;
         if (rd !== e[i]) $display("FAIL rst_read%0d got=%h exp=%h", i, rd, e[i]);
         else passed++;
         checks++;
         if (er !== 1'b0) $display("FAIL rst_err%0d got=%b exp=0", i, er);
         else passed++;
         checks++;
         if (lat !== 3) $display("FAIL rst_lat%0d got=%0d exp=3", i, lat);
         else passed++;
      end
   endtask

   task test_strobe();
      apb(16'h8, 32'hFFFFFFFF, 4'b0101, 1'b1, 3'b000);
      e[2] = 32'h5A0000FF;
      checks++;
      if (reg_q[95:64] !== e[2])
         $display("FAIL strb_reg2 got=%h exp=%h", reg_q[95:64], e[2]);
      else passed++;
      checks++;
      if (reg_wr_pulse !== 4'b0100)
         $display("FAIL strb_pulse got=%b exp=0100", reg_wr_pulse);
      else passed++;
      @(posedge pclk); #1;
      checks++;
      if (reg_wr_pulse !== 4'b0000)
         $display("FAIL strb_pulse_end got=%b exp=0000", reg_wr_pulse);
      else passed++;
      apb(16'h8, 32'h0, 4'b0000, 1'b1, 3'b000);
      checks++;
      if (er !== 1'b0) $display("FAIL strb0_err got=%b exp=0", er);
      else passed++;
      checks++;
      if (reg_q[95:64] !== e[2])
         $display("FAIL strb0_reg2 got=%h exp=%h", reg_q[95:64], e[2]);
      else passed++;
   endtask

   task test_hw_load();
      hw_wdata[95:64]  = 32'hFFFFFFFF;
      hw_wdata[127:96] = 32'h12345678;
      hw_we = 4'b1100;
      @(posedge pclk); #1;
      hw_we = 4'b0000;
      e[2] = 32'hFFFF00FF; e[3] = 32'h12345678;
      checks++;
      if (reg_q !== {e[3], e[2], e[1], e[0]})
         $display("FAIL hwld_regq got=%h exp=%h", reg_q,
                  {e[3], e[2], e[1], e[0]});
      else passed++;
      apb(16'h8, 32'h0, 4'hF, 1'b1, 3'b000);
      e[2] = 32'hFFFF0000;
      checks++;
      if (reg_q[95:64] !== e[2])
         $display("FAIL hwld_rw got=%h exp=%h", reg_q[95:64], e[2]);
      else passed++;
      apb(16'hC, 32'h0, 4'h0, 1'b0, 3'b000);
      checks++;
      if (rd !== e[3]) $display("FAIL hwld_read got=%h exp=%h", rd, e[3]);
      else passed++;
   endtask

   task test_w1c_irq();
      apb(16'h4, 32'h8, 4'hF, 1'b1, 3'b000);
      e[1] = 32'h8;
      hw_set[31:0] = 32'h40000008;
      @(posedge pclk); #1;
      hw_set[31:0] = 32'h0;
      e[0] = 32'h12000008;
      checks++;
      if (reg_q !== {e[3], e[2], e[1], e[0]})
         $display("FAIL w1c_set got=%h exp=%h", reg_q,
                  {e[3], e[2], e[1], e[0]});
      else passed++;
      checks++;
      if (irq !== 1'b0) $display("FAIL irq_lag got=%b exp=0", irq);
      else passed++;
      @(posedge pclk); #1;
      checks++;
      if (irq !== 1'b1) $display("FAIL irq_rise got=%b exp=1", irq);
      else passed++;
      hw_set[31:0] = 32'h8;
      apb(16'h0, 32'h8, 4'hF, 1'b1, 3'b000);
      hw_set[31:0] = 32'h0;
      checks++;
      if (reg_q[31:0] !== e[0])
         $display("FAIL w1c_setwins got=%h exp=%h", reg_q[31:0], e[0]);
      else passed++;
      apb(16'h0, 32'h8, 4'hF, 1'b1, 3'b000);
      e[0] = 32'h12000000;
      checks++;
      if (reg_q[31:0] !== e[0])
         $display("FAIL w1c_clear got=%h exp=%h", reg_q[31:0], e[0]);
      else passed++;
      checks++;
      if (irq !== 1'b1) $display("FAIL irq_hold got=%b exp=1", irq);
      else passed++;
      @(posedge pclk); #1;
      checks++;
      if (irq !== 1'b0) $display("FAIL irq_fall got=%b exp=0", irq);
      else passed++;
   endtask

   task test_errors();
      apb(16'h10, 32'h0, 4'h0, 1'b0, 3'b000);
      checks++;
      if ({er, rd} !== {1'b1, 32'h0})
         $display("FAIL err_range got=%b/%h exp=1/0", er, rd);
      else passed++;
      apb(16'h2, 32'hFF, 4'hF, 1'b1, 3'b000);
      checks++;
      if (er !== 1'b1) $display("FAIL err_misalign got=%b exp=1", er);
      else passed++;
      checks++;
      if (reg_q !== {e[3], e[2], e[1], e[0]})
         $display("FAIL err_nochange got=%h exp=%h", reg_q,
                  {e[3], e[2], e[1], e[0]});
      else passed++;
      checks++;
      if (reg_wr_pulse !== 4'b0000)
         $display("FAIL err_pulse got=%b exp=0000", reg_wr_pulse);
      else passed++;
      apb(16'h6, 32'h0, 4'h0, 1'b0, 3'b000);
      checks++;
      if ({er, rd} !== {1'b1, 32'h0})
         $display("FAIL err_rdmis got=%b/%h exp=1/0", er, rd);
      else passed++;
   endtask

   task test_wprot();
      write_protect_en = 1'b1;
      apb(16'h4, 32'hFFFF, 4'hF, 1'b1, 3'b000);
      write_protect_en = 1'b0;
      checks++;
      if (er !== 1'b1) $display("FAIL wp_err got=%b exp=1", er);
      else passed++;
      checks++;
      if ({reg_q, reg_wr_pulse} !== {e[3], e[2], e[1], e[0], 4'b0000})
         $display("FAIL wp_nochange got=%h/%b exp=%h", reg_q, reg_wr_pulse,
                  {e[3], e[2], e[1], e[0]});
      else passed++;
      apb(16'h4, 32'hFFFF, 4'hF, 1'b1, 3'b000);
      e[1] = 32'hFFFF;
      checks++;
      if ({er, reg_wr_pulse, reg_q[63:32]} !== {1'b0, 4'b0010, e[1]})
         $display("FAIL wp_ok got=%b/%b/%h exp=0/0010/%h",
                  er, reg_wr_pulse, reg_q[63:32], e[1]);
      else passed++;
   endtask

   task test_sec();
      apb(16'h4, 32'h5, 4'hF, 1'b1, 3'b010);
`ifdef APB_CSR_BANK_SEC_EN
      checks++;
      if ({er, reg_q[63:32]} !== {1'b1, e[1]})
         $display("FAIL sec_block got=%b/%h exp=1/%h", er, reg_q[63:32], e[1]);
      else passed++;
      apb(16'h4, 32'h5, 4'hF, 1'b1, 3'b000);
`endif
      e[1] = 32'h5;
      checks++;
      if ({er, reg_q[63:32]} !== {1'b0, e[1]})
         $display("FAIL sec_ok got=%b/%h exp=0/%h", er, reg_q[63:32], e[1]);
      else passed++;
      apb(16'h8, 32'h0, 4'h0, 1'b0, 3'b010);
      checks++;
      if ({er, rd} !== {1'b0, e[2]})
         $display("FAIL sec_nonsec got=%b/%h exp=0/%h", er, rd, e[2]);
      else passed++;
   endtask

   task test_back_to_back();
      apb(16'h4, 32'h77, 4'hF, 1'b1, 3'b000);
      e[1] = 32'h77;
      apb(16'h4, 32'h0, 4'h0, 1'b0, 3'b000);
      checks++;
      if ({rd, lat} !== {e[1], 32'd3})
         $display("FAIL b2b_rd1 got=%h/%0d exp=%h/3", rd, lat, e[1]);
      else passed++;
      apb(16'hC, 32'h0, 4'h0, 1'b0, 3'b000);
      checks++;
      if ({rd, lat} !== {e[3], 32'd3})
         $display("FAIL b2b_rd2 got=%h/%0d exp=%h/3", rd, lat, e[3]);
      else passed++;
   endtask

   task test_reset_mid();
      paddr = 16'h4; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pwrite = 1'b1;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      preset_n = 1'b0;
      #1;
      checks++;
      if ({pready, reg_wr_pulse, irq} !== 6'd0)
         $display("FAIL mid_flags got=%b exp=0", {pready, reg_wr_pulse, irq});
      else passed++;
      checks++;
      if (reg_q !== RSTV) $display("FAIL mid_regq got=%h exp=%h", reg_q, RSTV);
      else passed++;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge pclk); #1;
      preset_n = 1'b1;
      @(posedge pclk); #1;
      apb(16'h4, 32'h0, 4'h0, 1'b0, 3'b000);
      checks++;
      if ({er, rd} !== {1'b0, 32'h0})
         $display("FAIL mid_read got=%b/%h exp=0/0", er, rd);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_strobe();
      test_hw_load();
      test_w1c_irq();
      test_errors();
      test_wprot();
      test_sec();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
